// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter that shares one UART TX write port between N_REQ requesters.
// Optional idle-lock watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [N_REQ-1:0]     req_last_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    output logic [N_REQ-1:0]     req_ready_o,
    input  logic                 uart_tx_full_i,
    output logic                 uart_we_o,
    output logic [7:0]           uart_tx_wdata_o,
    output logic [2:0]           grant_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e     state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [2:0] rr_q, rr_d;
    logic [2:0] winner;
    logic       found;
    logic       g_valid, g_last;
    logic [7:0] g_data;
    logic [2:0] grant_inc;
    logic       wd_fire;
    logic       timeout_d;

    // First valid lane at or after the round-robin pointer, wrapping mod N_REQ.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            idx = (int'(rr_q) + i) % int'(N_REQ);
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                winner = 3'(idx);
            end
        end
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant_q == 3'(i)) begin
                g_valid = req_valid_i[i];
                g_last  = req_last_i[i];
                g_data  = req_data_i[8*i +: 8];
            end
        end
    end

    assign grant_inc = (grant_q == 3'(N_REQ - 1)) ? 3'd0 : grant_q + 3'd1;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q;

    // Only cycles where the owner has nothing to send count; FIFO-full stalls keep valid high.
    assign wd_fire = (state_q == StLocked) && !g_valid && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == StLocked && !g_valid && !wd_fire) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign wd_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        logic we;
        state_d         = state_q;
        grant_d         = grant_q;
        rr_d            = rr_q;
        timeout_d       = 1'b0;
        req_ready_o     = '0;
        uart_tx_wdata_o = '0;
        we              = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = winner;
                    state_d = StLocked;
                end
            end
            StLocked: begin
                for (int i = 0; i < int'(N_REQ); i++) begin
                    if (grant_q == 3'(i)) req_ready_o[i] = ~uart_tx_full_i;
                end
                we = g_valid & ~uart_tx_full_i;
                if (we) uart_tx_wdata_o = g_data;
                if (we && g_last) begin
                    state_d = StIdle;
                    rr_d    = grant_inc;
                end else if (wd_fire) begin
                    state_d   = StIdle;
                    rr_d      = grant_inc;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        uart_we_o = we;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == StLocked);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter: lane queues drive requesters, UART writes are
// logged and compared against hand-computed sequences.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 1024;
`endif

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [NR-1:0]   req_valid_i;
    logic [NR-1:0]   req_last_i;
    logic [8*NR-1:0] req_data_i;
    logic [NR-1:0]   req_ready_o;
    logic            uart_tx_full_i;
    logic            uart_we_o;
    logic [7:0]      uart_tx_wdata_o;
    logic [2:0]      grant_o;
    logic            busy_o;
    logic            timeout_o;

    always #5 clk_i = ~clk_i;

    uart_tx_arbiter #(
        .N_REQ          (NR),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid_i),
        .req_last_i      (req_last_i),
        .req_data_i      (req_data_i),
        .req_ready_o     (req_ready_o),
        .uart_tx_full_i  (uart_tx_full_i),
        .uart_we_o       (uart_we_o),
        .uart_tx_wdata_o (uart_tx_wdata_o),
        .grant_o         (grant_o),
        .busy_o          (busy_o),
        .timeout_o       (timeout_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Per-lane byte queues: {last, data}.
    logic [8:0]    mem [NR][16];
    int            head [NR];
    int            tail [NR];
    logic [NR-1:0] hold;
    int            cyc;
    logic [7:0]    wlog [$];
    int            wcyc [$];
    logic [2:0]    glog [$];
    logic          s_we, s_busy;
    logic [NR-1:0] s_ready;
    logic [2:0]    s_grant;
    int            to_cnt, to_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        mem[r][tail[r]] = {l, d};
        tail[r]++;
    endtask

    task automatic drive();
        for (int r = 0; r < NR; r++) begin
            if (head[r] < tail[r] && !hold[r]) begin
                req_valid_i[r]         = 1'b1;
                req_data_i[8*r +: 8]   = mem[r][head[r]][7:0];
                req_last_i[r]          = mem[r][head[r]][8];
            end else begin
                req_valid_i[r]         = 1'b0;
                req_data_i[8*r +: 8]   = 8'h00;
                req_last_i[r]          = 1'b0;
            end
        end
    endtask

    // One clock: drive, sample 1 ns later, pop accepted bytes after the edge.
    task automatic step();
        logic [NR-1:0] xfer;
        drive();
        #1;
        s_we    = uart_we_o;
        s_busy  = busy_o;
        s_ready = req_ready_o;
        s_grant = grant_o;
        xfer    = req_ready_o & req_valid_i;
        if (uart_we_o) begin
            wlog.push_back(uart_tx_wdata_o);
            wcyc.push_back(cyc);
            glog.push_back(grant_o);
        end
        if (timeout_o) begin
            to_cnt++;
            to_cyc = cyc;
        end
        @(posedge clk_i);
        for (int r = 0; r < NR; r++) if (xfer[r]) head[r]++;
        #1;
        cyc++;
    endtask

    task automatic new_test();
        wlog.delete();
        wcyc.delete();
        glog.delete();
        cyc    = 0;
        to_cnt = 0;
        to_cyc = -1;
    endtask

    task automatic do_reset();
        rst_ni         = 1'b0;
        uart_tx_full_i = 1'b0;
        hold           = '0;
        for (int r = 0; r < NR; r++) begin
            head[r] = 0;
            tail[r] = 0;
        end
        drive();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        new_test();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        // Reset with every lane requesting.
        rst_ni         = 1'b1;
        uart_tx_full_i = 1'b0;
        req_valid_i    = '0;
        req_last_i     = '0;
        req_data_i     = '0;
        hold           = '0;
        #2;
        rst_ni      = 1'b0;
        req_valid_i = '1;
        req_data_i  = 32'h44332211;
        @(posedge clk_i);
        #1;
        check("rst_we", 32'(uart_we_o), 32'h0);
        check("rst_ready", 32'(req_ready_o), 32'h0);
        check("rst_wdata", 32'(uart_tx_wdata_o), 32'h0);
        check("rst_grant", 32'(grant_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_timeout", 32'(timeout_o), 32'h0);
        rst_ni = 1'b1;
        #1;
        check("rel_idle_ready", 32'(req_ready_o), 32'h0);
        @(posedge clk_i);
        #1;
        check("rel_busy", 32'(busy_o), 32'h1);
        check("rel_grant", 32'(grant_o), 32'h0);
        check("rel_ready", 32'(req_ready_o), 32'h1);
        check("rel_wdata", 32'(uart_tx_wdata_o), 32'h11);
        do_reset();
        #1;
        check("midmsg_rst_busy", 32'(busy_o), 32'h0);
        #1;

        // Two 3-byte messages on lanes 0 and 2.
        push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
        push(2, 8'h61, 1'b0); push(2, 8'h62, 1'b0); push(2, 8'h63, 1'b1);
        for (int i = 0; i < 10; i++) step();
        begin
            logic [7:0] eb [6] = '{8'h41, 8'h42, 8'h43, 8'h61, 8'h62, 8'h63};
            int         ec [6] = '{1, 2, 3, 5, 6, 7};
            logic [2:0] eg [6] = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2};
            check("msg2_count", 32'(wlog.size()), 32'd6);
            for (int i = 0; i < 6; i++) begin
                check($sformatf("msg2_byte%0d", i), 32'(wlog[i]), 32'(eb[i]));
                check($sformatf("msg2_cyc%0d", i), 32'(wcyc[i]), 32'(ec[i]));
                check($sformatf("msg2_grant%0d", i), 32'(glog[i]), 32'(eg[i]));
            end
        end

        // FIFO-full stall for 5 cycles in the middle of a lane-1 message.
        do_reset();
        push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b0); push(1, 8'h13, 1'b1);
        for (int i = 0; i < 10; i++) begin
            uart_tx_full_i = (cyc >= 2 && cyc <= 6);
            step();
            if (i >= 2 && i <= 6) begin
                check($sformatf("full_we_c%0d", i), 32'(s_we), 32'h0);
                check($sformatf("full_ready_c%0d", i), 32'(s_ready), 32'h0);
            end
        end
        uart_tx_full_i = 1'b0;
        begin
            logic [7:0] eb [3] = '{8'h11, 8'h12, 8'h13};
            int         ec [3] = '{1, 7, 8};
            check("full_count", 32'(wlog.size()), 32'd3);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("full_byte%0d", i), 32'(wlog[i]), 32'(eb[i]));
                check($sformatf("full_cyc%0d", i), 32'(wcyc[i]), 32'(ec[i]));
            end
        end

        // Fairness: four lanes, four single-beat messages each.
        do_reset();
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < NR; r++) push(r, 8'(r * 16 + k), 1'b1);
        for (int i = 0; i < 34; i++) step();
        check("fair_count", 32'(wlog.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fair_grant%0d", i), 32'(glog[i]), 32'(i % 4));
            check($sformatf("fair_byte%0d", i), 32'(wlog[i]), 32'((i % 4) * 16 + i / 4));
            check($sformatf("fair_cyc%0d", i), 32'(wcyc[i]), 32'(2 * i + 1));
        end

        // Lane 1 drops valid mid-message while lane 3 waits.
        do_reset();
        push(1, 8'h21, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h23, 1'b1);
        push(3, 8'h31, 1'b1);
        for (int i = 0; i < 10; i++) begin
            hold[1] = (cyc >= 2 && cyc <= 4);
            step();
            if (i >= 2 && i <= 4) begin
                check($sformatf("drop_busy_c%0d", i), 32'(s_busy), 32'h1);
                check($sformatf("drop_grant_c%0d", i), 32'(s_grant), 32'h1);
                check($sformatf("drop_we_c%0d", i), 32'(s_we), 32'h0);
            end
        end
        hold = '0;
        begin
            logic [7:0] eb [4] = '{8'h21, 8'h22, 8'h23, 8'h31};
            int         ec [4] = '{1, 5, 6, 8};
            check("drop_count", 32'(wlog.size()), 32'd4);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("drop_byte%0d", i), 32'(wlog[i]), 32'(eb[i]));
                check($sformatf("drop_cyc%0d", i), 32'(wcyc[i]), 32'(ec[i]));
            end
        end

        // Owner goes silent after one byte; lane 1 is waiting.
        do_reset();
        push(0, 8'h51, 1'b0); push(0, 8'h52, 1'b1);
        push(1, 8'h71, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
        for (int i = 0; i < 14; i++) begin
            hold[0] = (cyc >= 2);
            step();
        end
        check("wd_count", 32'(wlog.size()), 32'd2);
        check("wd_byte0", 32'(wlog[0]), 32'h51);
        check("wd_byte1", 32'(wlog[1]), 32'h71);
        check("wd_cyc1", 32'(wcyc[1]), 32'd11);
        check("wd_grant1", 32'(glog[1]), 32'd1);
        check("wd_pulses", 32'(to_cnt), 32'd1);
        check("wd_pulse_cyc", 32'(to_cyc), 32'd10);
`else
        for (int i = 0; i < 110; i++) begin
            hold[0] = (cyc >= 2);
            step();
        end
        check("lock_count", 32'(wlog.size()), 32'd1);
        check("lock_byte0", 32'(wlog[0]), 32'h51);
        check("lock_busy", 32'(s_busy), 32'h1);
        check("lock_grant", 32'(s_grant), 32'h0);
        check("lock_pulses", 32'(to_cnt), 32'd0);
`endif
        hold = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
